// File: rtl/sw_pattern_sequencer_pkg.sv
// sw_seq_pkg: state encoding and the fixed switch-code pattern shared by the sequencer.
package sw_seq_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam int NUM_STEPS = 6;
    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);
    localparam logic [2:0] PATTERN [NUM_STEPS] = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b100, 3'b000};
    function automatic logic [2:0] pattern_code(input logic [2:0] idx);
        return (idx <= LAST_STEP) ? PATTERN[idx] : 3'b000;
    endfunction
endpackage

// File: rtl/sw_pattern_sequencer_if.sv
// sw_pattern_sequencer_if: control inputs and switch-code outputs of the pattern sequencer.
interface sw_pattern_sequencer_if;
    logic       start;
    logic       stop;
    logic       manual_en;
    logic [2:0] manual_sw;
    logic [2:0] sw_out;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;
    modport master (output start, stop, manual_en, manual_sw, input sw_out, busy, step_idx, done);
    modport slave  (input start, stop, manual_en, manual_sw, output sw_out, busy, step_idx, done);
endinterface

// File: rtl/sw_pattern_sequencer_dwell_timer.sv
// dwell_timer: per-step cycle counter; expire is high on the last cycle of a step.
module dwell_timer #(
    parameter int unsigned DWELL_CYCLES = 100000000,
    parameter int          CNT_W        = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= count + 1'b1;
    end
    assign expire = (count == LAST);
endmodule

// File: rtl/sw_pattern_sequencer.sv
// sw_pattern_sequencer: steps the LED FSM switch code through a fixed pattern with manual override.
// Define SW_PATTERN_LOOP_EN to repeat the pattern until stop instead of running it once.
module sw_pattern_sequencer
    import sw_seq_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 100000000,
    parameter int          CNT_W        = 32
) (
    input logic clk,
    input logic rst_n,
    sw_pattern_sequencer_if.slave bus
);
    logic [1:0] state;
    logic [2:0] step;
    logic [2:0] sw;
    logic       busy_q;
    logic       done_q;
    logic       expire;
    logic       cnt_en;
    logic       cnt_clr;
    // Manual entry in an expiry cycle holds the count so the step still finishes after release.
    assign cnt_en  = (state == RUN) && !bus.stop && !expire;
    assign cnt_clr = (state == IDLE) || bus.stop || ((state == RUN) && !bus.manual_en && expire);
    dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES), .CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (cnt_en),
        .clr    (cnt_clr),
        .expire (expire)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            step   <= '0;
            sw     <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start && !bus.stop) begin
                    state  <= RUN;
                    step   <= '0;
                    sw     <= pattern_code(3'd0);
                    busy_q <= 1'b1;
                end else begin
                    sw <= bus.manual_en ? bus.manual_sw : 3'b000;
                end
            end else if (bus.stop) begin
                state  <= IDLE;
                step   <= '0;
                sw     <= '0;
                busy_q <= 1'b0;
            end else if (bus.manual_en) begin
                state <= PAUSE;
                sw    <= bus.manual_sw;
            end else if (state == PAUSE) begin
                state <= RUN;
                sw    <= pattern_code(step);
            end else if (expire) begin
                if (step != LAST_STEP) begin
                    step <= step + 3'd1;
                    sw   <= pattern_code(step + 3'd1);
                end else begin
                    done_q <= 1'b1;
                    step   <= '0;
`ifdef SW_PATTERN_LOOP_EN
                    sw     <= pattern_code(3'd0);
`else
                    state  <= IDLE;
                    sw     <= '0;
                    busy_q <= 1'b0;
`endif
                end
            end
        end
    end
    assign bus.sw_out   = sw;
    assign bus.busy     = busy_q;
    assign bus.step_idx = step;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_sw_pattern_sequencer.sv
// tb_sw_pattern_sequencer: directed and random checks of the sequencer against a cycle-level reference model.
module tb_sw_pattern_sequencer;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    sw_pattern_sequencer_if bus();
    sw_pattern_sequencer #(.DWELL_CYCLES(D), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [2:0] rom [6] = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b100, 3'b000};
    // Model: mode 0 idle, 1 running, 2 paused; served = RUN cycles already spent in the current step.
    int m_mode, m_step, m_served;
    logic [2:0] m_sw;
    logic m_busy, m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_served = 0; m_sw = 3'b000; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (m_mode == 0) begin
            if (bus.start && !bus.stop) begin
                m_mode = 1; m_step = 0; m_served = 0; m_sw = rom[0]; m_busy = 1'b1;
            end else m_sw = bus.manual_en ? bus.manual_sw : 3'b000;
        end else if (bus.stop) begin
            model_reset();
        end else if (bus.manual_en) begin
            // The cycle just spent counts, except the step's final one, which is replayed after release.
            if (m_mode == 1 && m_served + 1 < D) m_served++;
            m_mode = 2; m_sw = bus.manual_sw;
        end else if (m_mode == 2) begin
            m_mode = 1; m_sw = rom[m_step];
        end else if (m_served + 1 < D) begin
            m_served++;
        end else if (m_step < 5) begin
            m_step++; m_served = 0; m_sw = rom[m_step];
        end else begin
            m_done = 1'b1; m_step = 0; m_served = 0;
`ifdef SW_PATTERN_LOOP_EN
            m_sw = rom[0];
`else
            m_mode = 0; m_sw = 3'b000; m_busy = 1'b0;
`endif
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".sw"}, 32'(bus.sw_out), 32'(m_sw));
        check({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
        check({tag, ".step"}, 32'(bus.step_idx), 32'(m_step));
        check({tag, ".done"}, 32'(bus.done), 32'(m_done));
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic do_stop();
        bus.stop = 1'b1; tick("stop");
        bus.stop = 1'b0;
    endtask

    initial begin
        int done_at;
        int done_cnt;
        bus.start = 1'b0; bus.stop = 1'b0; bus.manual_en = 1'b0; bus.manual_sw = 3'b000;
        model_reset();
        #12;
        check("reset.sw", 32'(bus.sw_out), 0);
        check("reset.busy", 32'(bus.busy), 0);
        check("reset.step", 32'(bus.step_idx), 0);
        check("reset.done", 32'(bus.done), 0);
        @(negedge clk) rst_n = 1'b1;
        ticks("idle", 2);

        // Full run: done 24 edges after the start-sampling edge.
        bus.start = 1'b1; tick("full.start");
        bus.start = 1'b0;
        check("full.first_code", 32'(bus.sw_out), 32'h1);
        done_at = -1;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            tick("full");
            if (bus.done) done_at = i;
        end
        check("full.done_latency", done_at, 24);
`ifndef SW_PATTERN_LOOP_EN
        check("full.busy_fall", 32'(bus.busy), 0);
`endif
        tick("full.after");
        do_stop();

        // Stop abort at step 2, count 1.
        bus.start = 1'b1; tick("abort.start");
        bus.start = 1'b0;
        ticks("abort.run", 9);
        check("abort.step_before", 32'(bus.step_idx), 2);
        do_stop();
        check("abort.sw", 32'(bus.sw_out), 0);
        check("abort.busy", 32'(bus.busy), 0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin tick("abort.idle"); done_cnt += int'(bus.done); end
        check("abort.no_done", done_cnt, 0);

        // Manual override at step 1, count 2.
        bus.start = 1'b1; tick("man.start");
        bus.start = 1'b0;
        ticks("man.run", 6);
        bus.manual_en = 1'b1; bus.manual_sw = 3'b111;
        ticks("man.hold", 10);
        check("man.hold_sw", 32'(bus.sw_out), 32'h7);
        check("man.hold_step", 32'(bus.step_idx), 1);
        bus.manual_en = 1'b0;
        tick("man.rel");
        check("man.rel_sw", 32'(bus.sw_out), 32'h2);
        tick("man.next");
        check("man.next_sw", 32'(bus.sw_out), 32'h4);
        do_stop();

        // Priority: stop beats manual_en; manual_en in an expiry cycle pauses without advancing.
        bus.start = 1'b1; tick("pri.start");
        bus.start = 1'b0;
        ticks("pri.run", 2);
        bus.stop = 1'b1; bus.manual_en = 1'b1; bus.manual_sw = 3'b101;
        tick("pri.stop_man");
        check("pri.stop_sw", 32'(bus.sw_out), 0);
        check("pri.stop_busy", 32'(bus.busy), 0);
        bus.stop = 1'b0; bus.manual_en = 1'b0;
        bus.start = 1'b1; bus.stop = 1'b1; tick("pri.start_stop");
        check("pri.start_stop_busy", 32'(bus.busy), 0);
        bus.stop = 1'b0; tick("pri.start2");
        bus.start = 1'b0;
        ticks("pri.run2", 3);
        bus.manual_en = 1'b1; bus.manual_sw = 3'b011;
        tick("pri.exp_man");
        check("pri.exp_step", 32'(bus.step_idx), 0);
        check("pri.exp_sw", 32'(bus.sw_out), 32'h3);
        bus.manual_en = 1'b0;
        ticks("pri.resume", 2);
        check("pri.resume_step", 32'(bus.step_idx), 1);
        do_stop();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.stop = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 11) == 0) bus.manual_en = ~bus.manual_en;
            bus.manual_sw = 3'($urandom_range(0, 7));
            tick("rand");
        end
        bus.start = 1'b0; bus.manual_en = 1'b0;
        do_stop();

        // Asynchronous reset in the middle of step 3.
        bus.start = 1'b1; tick("arst.start");
        bus.start = 1'b0;
        ticks("arst.run", 13);
        check("arst.step_before", 32'(bus.step_idx), 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst.sw", 32'(bus.sw_out), 0);
        check("arst.busy", 32'(bus.busy), 0);
        check("arst.step", 32'(bus.step_idx), 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        ticks("arst.idle", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
